// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer: opcode width, opcode encodings and FSM states.
// Imported by the interface, the PC unit and the top.
package fetch_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_JPOS  = 3'b100,
        OP_JZ    = 3'b101,
        OP_JMP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer (master), instruction memory and the execute datapath.
// The master modport is the sequencer's view; slave is the memory/datapath view.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 5
);
    localparam int IR_W = fetch_seq_pkg::OP_W + ADDR_W;

    logic                          start;
    logic [IR_W-1:0]               mem_rdata;
    logic                          mem_ready;
    logic                          exec_done;
    logic                          acc_zero;
    logic                          acc_pos;
    logic [ADDR_W-1:0]             mem_addr;
    logic                          mem_rd;
    logic [fetch_seq_pkg::OP_W-1:0] ir_op;
    logic [ADDR_W-1:0]             ir_addr;
    logic [ADDR_W-1:0]             pc;
    logic                          exec_valid;
    logic                          busy;
    logic                          halted;

    modport master (
        input  start, mem_rdata, mem_ready, exec_done, acc_zero, acc_pos,
        output mem_addr, mem_rd, ir_op, ir_addr, pc, exec_valid, busy, halted
    );

    modport slave (
        output start, mem_rdata, mem_ready, exec_done, acc_zero, acc_pos,
        input  mem_addr, mem_rd, ir_op, ir_addr, pc, exec_valid, busy, halted
    );

endinterface

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register: async clear to RESET_PC, branch-target load, and
// modulo-2^ADDR_W increment. Load wins over increment.
module pc_unit #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-decode-execute controller owning PC and IR, with memory-ready and exec-done handshakes.
// Define COND_BRANCH_EN to enable JZ/JPOS; otherwise those opcodes act as 2-cycle NOPs.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clear,
    fetch_sequencer_if.master bus
);

    localparam int IR_W = OP_W + ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [IR_W-1:0]   ir;
    logic [ADDR_W-1:0] pc;
    logic              ir_load;
    logic              pc_load;
    logic              pc_inc;

    logic mem_rd_r;
    logic exec_valid_r;
    logic busy_r;
    logic halted_r;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .clear  (clear),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (ir[ADDR_W-1:0]),
        .pc     (pc)
    );

    // Status outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state        <= S_IDLE;
            ir           <= '0;
            mem_rd_r     <= 1'b0;
            exec_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state        <= state_next;
            if (ir_load) begin
                ir <= bus.mem_rdata;
            end
            mem_rd_r     <= (state_next == S_FETCH);
            exec_valid_r <= (state_next == S_EXEC);
            busy_r       <= (state_next == S_FETCH) || (state_next == S_DECODE)
                            || (state_next == S_EXEC);
            halted_r     <= (state_next == S_HALT);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_FETCH;
                case (opcode_t'(ir[IR_W-1:ADDR_W]))
                    OP_HALT: state_next = S_HALT;
                    OP_JMP:  pc_load    = 1'b1;
                    OP_JZ: begin
`ifdef COND_BRANCH_EN
                        pc_load = bus.acc_zero;
`endif
                    end
                    OP_JPOS: begin
`ifdef COND_BRANCH_EN
                        pc_load = bus.acc_pos;
`endif
                    end
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // During EXEC the bus carries the operand address; otherwise it points at the next instruction.
    assign bus.mem_addr   = (state == S_EXEC) ? ir[ADDR_W-1:0] : pc;
    assign bus.mem_rd     = mem_rd_r;
    assign bus.exec_valid = exec_valid_r;
    assign bus.busy       = busy_r;
    assign bus.halted     = halted_r;
    assign bus.ir_op      = ir[IR_W-1:ADDR_W];
    assign bus.ir_addr    = ir[ADDR_W-1:0];
    assign bus.pc         = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a fetch/exec scoreboard; expectations follow
// the COND_BRANCH_EN setting of the build.
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    localparam int ADDR_W = 5;
    localparam int IR_W   = OP_W + ADDR_W;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_pc;

    logic [IR_W-1:0]   mem [32];
    logic [ADDR_W-1:0] fetch_q [$];
    logic [IR_W-1:0]   exec_q  [$];

    fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (5'd0)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Non-ready cycles present a HALT word so an early IR load shows up as a wrong opcode.
    assign bus.mem_rdata = bus.mem_ready ? mem[bus.mem_addr] : 8'hE7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic unexpected(input string tag, input logic [31:0] obs);
        total++;
        bad++;
        $error("FAIL %s: observed=%0h expected=no transaction", tag, obs);
    endtask

    // Scoreboard the transaction completing at the coming edge, then advance one cycle.
    task automatic run_cycle();
        logic [IR_W-1:0] e;
        if (bus.mem_rd && bus.mem_ready) begin
            if (fetch_q.size() > 0) check("fetch_addr", 32'(bus.mem_addr), 32'(fetch_q.pop_front()));
            else unexpected("fetch_extra", 32'(bus.mem_addr));
        end
        if (bus.exec_valid && bus.exec_done) begin
            if (exec_q.size() > 0) begin
                e = exec_q.pop_front();
                check("exec_word", 32'({bus.ir_op, bus.ir_addr}), 32'(e));
                check("exec_addr", 32'(bus.mem_addr), 32'(e[ADDR_W-1:0]));
            end else begin
                unexpected("exec_extra", 32'({bus.ir_op, bus.ir_addr}));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.exec_done = 1'b1;
        bus.acc_zero  = 1'b0;
        bus.acc_pos   = 1'b0;

        // Reset state
        #2;
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_ir", 32'({bus.ir_op, bus.ir_addr}), 32'd0);
        @(negedge clk);
        clear = 1'b0;

        // Program [ADD @1, HALT]
        mem[0] = 8'h41;
        mem[1] = 8'hE0;
        fetch_q.push_back(5'd0);
        fetch_q.push_back(5'd1);
        exec_q.push_back(8'h41);
        bus.start = 1'b1;
        run_cycle();
        check("p1_c1_mem_rd", 32'(bus.mem_rd), 32'd1);
        check("p1_c1_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        run_cycle();
        check("p1_dec_pc", 32'(bus.pc), 32'd1);
        check("p1_dec_ir", 32'({bus.ir_op, bus.ir_addr}), 32'h41);
        check("p1_dec_mem_rd", 32'(bus.mem_rd), 32'd0);
        run_cycle();
        check("p1_exec_valid", 32'(bus.exec_valid), 32'd1);
        check("p1_exec_mem_addr", 32'(bus.mem_addr), 32'd1);
        run_cycle();
        check("p1_c4_mem_rd", 32'(bus.mem_rd), 32'd1);
        check("p1_c4_exec_valid", 32'(bus.exec_valid), 32'd0);
        check("p1_c4_mem_addr", 32'(bus.mem_addr), 32'd1);
        run_cycle();
        check("p1_dec2_ir", 32'({bus.ir_op, bus.ir_addr}), 32'hE0);
        run_cycle();
        check("p1_halted", 32'(bus.halted), 32'd1);
        check("p1_halt_busy", 32'(bus.busy), 32'd0);
        check("p1_halt_pc", 32'(bus.pc), 32'd2);

        // Resume after HALT; JMP 31 at pc=31 with wrap; start held high while busy
        mem[2]  = 8'hDF;
        mem[31] = 8'hDF;
        fetch_q.push_back(5'd2);
        fetch_q.push_back(5'd31);
        fetch_q.push_back(5'd31);
        bus.start = 1'b1;
        run_cycle();
        check("p2_resume_addr", 32'(bus.mem_addr), 32'd2);
        run_cycle();
        check("p2_dec_pc", 32'(bus.pc), 32'd3);
        run_cycle();
        check("p2_jmp_pc", 32'(bus.pc), 32'd31);
        check("p2_jmp_fetch", 32'(bus.mem_rd), 32'd1);
        run_cycle();
        check("p2_wrap_pc", 32'(bus.pc), 32'd0);
        check("p2_wrap_ir_addr", 32'(bus.ir_addr), 32'd31);
        run_cycle();
        check("p2_jmp2_pc", 32'(bus.pc), 32'd31);
        mem[31] = 8'hE0;
        run_cycle();
        check("p2_dec_halt_ir", 32'({bus.ir_op, bus.ir_addr}), 32'hE0);
        bus.start = 1'b0;
        run_cycle();
        check("p2_halted", 32'(bus.halted), 32'd1);
        check("p2_halt_pc", 32'(bus.pc), 32'd0);
        run_cycle();
        check("p2_halt_hold", 32'(bus.halted), 32'd1);

        // JZ 7 taken when acc_zero=1 in DECODE; JZ 3 not taken with acc_zero=0
        mem[0] = 8'hA7;
        mem[7] = 8'hA3;
        mem[8] = 8'hE0;
        fetch_q.push_back(5'd0);
`ifdef COND_BRANCH_EN
        fetch_q.push_back(5'd7);
        fetch_q.push_back(5'd8);
`else
        fetch_q.push_back(5'd1);
`endif
        bus.start = 1'b1;
        run_cycle();
        bus.start = 1'b0;
        run_cycle();
        bus.acc_zero = 1'b1;
        run_cycle();
        bus.acc_zero = 1'b0;
`ifdef COND_BRANCH_EN
        check("p3_jz_taken_pc", 32'(bus.pc), 32'd7);
        run_cycle();
        run_cycle();
        check("p3_jz_not_taken_pc", 32'(bus.pc), 32'd8);
        run_cycle();
        run_cycle();
        exp_pc = 9;
`else
        check("p3_jz_nop_pc", 32'(bus.pc), 32'd1);
        run_cycle();
        run_cycle();
        exp_pc = 2;
`endif
        check("p3_halted", 32'(bus.halted), 32'd1);
        check("p3_halt_pc", 32'(bus.pc), 32'(exp_pc));

        // Memory wait of 3 cycles on LOAD 5, then exec stall aborted by clear
        mem[exp_pc]     = 8'h05;
        mem[exp_pc + 1] = 8'hE0;
        fetch_q.push_back(5'(exp_pc));
        bus.mem_ready = 1'b0;
        bus.exec_done = 1'b0;
        bus.start     = 1'b1;
        run_cycle();
        bus.start = 1'b0;
        check("p4_wait0_mem_rd", 32'(bus.mem_rd), 32'd1);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check("p4_wait_mem_rd", 32'(bus.mem_rd), 32'd1);
            check("p4_wait_ir", 32'({bus.ir_op, bus.ir_addr}), 32'hE0);
            check("p4_wait_pc", 32'(bus.pc), 32'(exp_pc));
        end
        bus.mem_ready = 1'b1;
        run_cycle();
        check("p4_ready_pc", 32'(bus.pc), 32'(exp_pc + 1));
        check("p4_ready_ir", 32'({bus.ir_op, bus.ir_addr}), 32'h05);
        check("p4_ready_mem_rd", 32'(bus.mem_rd), 32'd0);
        run_cycle();
        check("p4_exec1_valid", 32'(bus.exec_valid), 32'd1);
        check("p4_exec1_addr", 32'(bus.mem_addr), 32'd5);
        bus.start = 1'b1;
        run_cycle();
        check("p4_exec2_valid", 32'(bus.exec_valid), 32'd1);
        check("p4_exec2_no_fetch", 32'(bus.mem_rd), 32'd0);
        bus.start = 1'b0;
        run_cycle();
        check("p4_exec3_valid", 32'(bus.exec_valid), 32'd1);
        clear = 1'b1;
        #1;
        check("p4_clr_exec_valid", 32'(bus.exec_valid), 32'd0);
        check("p4_clr_busy", 32'(bus.busy), 32'd0);
        check("p4_clr_pc", 32'(bus.pc), 32'd0);
        check("p4_clr_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("p4_clr_ir", 32'({bus.ir_op, bus.ir_addr}), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        run_cycle();
        check("p4_idle_hold", 32'(bus.busy), 32'd0);

        // SUB 10 with exec_done delayed 5 cycles, then HALT
        mem[0] = 8'h6A;
        mem[1] = 8'hE0;
        fetch_q.push_back(5'd0);
        fetch_q.push_back(5'd1);
        exec_q.push_back(8'h6A);
        bus.start = 1'b1;
        run_cycle();
        bus.start = 1'b0;
        run_cycle();
        run_cycle();
        for (int i = 0; i < 5; i++) begin
            check("p5_exec_wait_valid", 32'(bus.exec_valid), 32'd1);
            run_cycle();
        end
        check("p5_exec_last_valid", 32'(bus.exec_valid), 32'd1);
        bus.exec_done = 1'b1;
        run_cycle();
        check("p5_post_exec_valid", 32'(bus.exec_valid), 32'd0);
        check("p5_post_exec_mem_rd", 32'(bus.mem_rd), 32'd1);
        run_cycle();
        run_cycle();
        check("p5_halted", 32'(bus.halted), 32'd1);
        check("p5_halt_pc", 32'(bus.pc), 32'd2);

        check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        check("exec_q_drained", 32'(exec_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
